// File: rtl/efpga_readback_tx_pkg.sv
// Shared controller definitions for the eFPGA readback/config byte paths:
// frame FSM state encodings, the default sync byte and a word-to-byte helper.
package efpga_readback_tx_pkg;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_SYNC = 3'd1,
    ST_LEN  = 3'd2,
    ST_DATA = 3'd3,
    ST_CSUM = 3'd4
  } rb_state_e;

  localparam logic [7:0] RB_SYNC_BYTE = 8'h5A;

  // Byte index 0 selects bits 31:24 so words leave MSB first.
  function automatic logic [7:0] word_byte(input logic [31:0] word, input logic [1:0] idx);
    logic [7:0] b;
    case (idx)
      2'd0:    b = word[31:24];
      2'd1:    b = word[23:16];
      2'd2:    b = word[15:8];
      default: b = word[7:0];
    endcase
    return b;
  endfunction

endpackage

// File: rtl/readback_word_fifo.sv
// Synchronous show-ahead FIFO; full/empty come from the registered count,
// so a pop never frees a slot for a write in the same cycle.
module readback_word_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 32
) (
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic [WIDTH-1:0] wr_data_i,
  input  logic             wr_en_i,
  output logic             full_o,
  input  logic             rd_en_i,
  output logic [WIDTH-1:0] rd_data_o,
  output logic             empty_o
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW:0] FULL_COUNT = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW:0]      count_q, count_d;
  logic             push, pop;

  assign full_o    = (count_q == FULL_COUNT);
  assign empty_o   = (count_q == '0);
  assign rd_data_o = mem_q[rd_ptr_q];

  always_comb begin
    push     = wr_en_i && !full_o;
    pop      = rd_en_i && !empty_o;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    if (push && !pop)      count_d = count_q + 1'b1;
    else if (pop && !push) count_d = count_q - 1'b1;
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: the pointers alone define what is valid.
  always_ff @(posedge clk_i) begin
    if (push) mem_q[wr_ptr_q] <= wr_data_i;
  end

endmodule

// File: rtl/efpga_readback_tx.sv
// Frames buffered eFPGA readback words into a byte stream for the USB CDC IN
// channel: SYNC, length, data bytes MSB first, XOR checksum.
module efpga_readback_tx
  import efpga_readback_tx_pkg::*;
#(
  parameter int         FIFO_DEPTH = 4,
  parameter logic [7:0] SYNC_BYTE  = RB_SYNC_BYTE
) (
  input  logic        clk_i,
  input  logic        reset_i,
  input  logic [31:0] word_data_i,
  input  logic        word_valid_i,
  output logic        word_ready_o,
  input  logic        frame_start_i,
  input  logic [7:0]  frame_len_i,
  output logic        busy_o,
  output logic        frame_done_o,
  output logic [7:0]  in_data_o,
  output logic        in_valid_o,
  input  logic        in_ready_i
);

  rb_state_e   state_q, state_d;
  logic [7:0]  len_q, len_d;
  logic [7:0]  word_cnt_q, word_cnt_d;
  logic [1:0]  byte_cnt_q, byte_cnt_d;
  logic [7:0]  csum_q, csum_d;
  logic        done_q, done_d;
  logic        fifo_full, fifo_empty, fifo_pop;
  logic [31:0] fifo_rdata;
  logic [7:0]  data_byte;

  readback_word_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(32)) u_fifo (
    .clk_i     (clk_i),
    .reset_i   (reset_i),
    .wr_data_i (word_data_i),
    .wr_en_i   (word_valid_i),
    .full_o    (fifo_full),
    .rd_en_i   (fifo_pop),
    .rd_data_o (fifo_rdata),
    .empty_o   (fifo_empty)
  );

  assign word_ready_o = !fifo_full;
  assign busy_o       = (state_q != ST_IDLE);
  assign frame_done_o = done_q;
  assign data_byte    = word_byte(fifo_rdata, byte_cnt_q);

  always_comb begin
    state_d    = state_q;
    len_d      = len_q;
    word_cnt_d = word_cnt_q;
    byte_cnt_d = byte_cnt_q;
    csum_d     = csum_q;
    done_d     = 1'b0;
    fifo_pop   = 1'b0;
    in_valid_o = 1'b0;
    in_data_o  = 8'h00;
    case (state_q)
      ST_IDLE: begin
        if (frame_start_i) begin
          state_d    = ST_SYNC;
          len_d      = frame_len_i;
          word_cnt_d = '0;
          byte_cnt_d = '0;
          csum_d     = '0;
        end
      end
      ST_SYNC: begin
        in_valid_o = 1'b1;
        in_data_o  = SYNC_BYTE;
        if (in_ready_i) state_d = ST_LEN;
      end
      ST_LEN: begin
        in_valid_o = 1'b1;
        in_data_o  = len_q;
        if (in_ready_i) begin
          csum_d  = csum_q ^ len_q;
          state_d = (len_q != 8'd0) ? ST_DATA : ST_CSUM;
        end
      end
      ST_DATA: begin
        // The FIFO head is read in place; the word is popped only after its last byte.
        in_valid_o = !fifo_empty;
        in_data_o  = fifo_empty ? 8'h00 : data_byte;
        if (!fifo_empty && in_ready_i) begin
          csum_d     = csum_q ^ data_byte;
          byte_cnt_d = byte_cnt_q + 2'd1;
          if (byte_cnt_q == 2'd3) begin
            fifo_pop   = 1'b1;
            word_cnt_d = word_cnt_q + 8'd1;
            if (word_cnt_q == len_q - 8'd1) state_d = ST_CSUM;
          end
        end
      end
      ST_CSUM: begin
        in_valid_o = 1'b1;
        in_data_o  = csum_q;
        if (in_ready_i) begin
          state_d = ST_IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q    <= ST_IDLE;
      len_q      <= '0;
      word_cnt_q <= '0;
      byte_cnt_q <= '0;
      csum_q     <= '0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      len_q      <= len_d;
      word_cnt_q <= word_cnt_d;
      byte_cnt_q <= byte_cnt_d;
      csum_q     <= csum_d;
      done_q     <= done_d;
    end
  end

endmodule

// File: tb/tb_efpga_readback_tx.sv
// Directed self-checking bench for efpga_readback_tx: inputs change and
// outputs are sampled on the falling edge, away from the active rising edge.
module tb_efpga_readback_tx;

  logic        clk;
  logic        reset_i;
  logic [31:0] word_data_i;
  logic        word_valid_i;
  logic        word_ready_o;
  logic        frame_start_i;
  logic [7:0]  frame_len_i;
  logic        busy_o;
  logic        frame_done_o;
  logic [7:0]  in_data_o;
  logic        in_valid_o;
  logic        in_ready_i;

  int          checkCount = 0;
  int          errorCount = 0;
  logic [7:0]  expQ[$];

  efpga_readback_tx #(.FIFO_DEPTH(4), .SYNC_BYTE(8'h5A)) dut (
    .clk_i         (clk),
    .reset_i       (reset_i),
    .word_data_i   (word_data_i),
    .word_valid_i  (word_valid_i),
    .word_ready_o  (word_ready_o),
    .frame_start_i (frame_start_i),
    .frame_len_i   (frame_len_i),
    .busy_o        (busy_o),
    .frame_done_o  (frame_done_o),
    .in_data_o     (in_data_o),
    .in_valid_o    (in_valid_o),
    .in_ready_i    (in_ready_i)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checkCount++;
    if (observed !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s: got %h, expected %h", tag, observed, expected);
    end
  endtask

  // Offers one word to the buffer for a single rising edge.
  task automatic applyStimulus(input logic [31:0] word);
    word_valid_i = 1'b1;
    word_data_i  = word;
    @(negedge clk);
    word_valid_i = 1'b0;
    word_data_i  = 32'h0;
  endtask

  // Pulses frame_start_i and checks that SYNC appears one cycle later.
  task automatic startFrame(input logic [7:0] len);
    frame_start_i = 1'b1;
    frame_len_i   = len;
    @(negedge clk);
    frame_start_i = 1'b0;
    frame_len_i   = 8'hEE;
    checkOutput("sync_valid", {31'd0, in_valid_o}, 32'd1);
    checkOutput("sync_byte", {24'd0, in_data_o}, 32'h5A);
    checkOutput("busy_in_frame", {31'd0, busy_o}, 32'd1);
    checkOutput("done_low_in_frame", {31'd0, frame_done_o}, 32'd0);
  endtask

  // Drains expQ against the byte stream; optional toggling backpressure
  // also checks that a stalled byte is held stable.
  task automatic receiveBytes(input bit toggle);
    int         budget = 0;
    bit         stalled = 1'b0;
    bit         rdy = 1'b1;
    logic [7:0] held = 8'h00;
    while (expQ.size() > 0 && budget < 400) begin
      if (stalled && in_valid_o) checkOutput("hold_stable", {24'd0, in_data_o}, {24'd0, held});
      rdy        = toggle ? ~rdy : 1'b1;
      in_ready_i = rdy;
      if (in_valid_o && rdy) begin
        checkOutput("stream_byte", {24'd0, in_data_o}, {24'd0, expQ.pop_front()});
        stalled = 1'b0;
      end else if (in_valid_o) begin
        stalled = 1'b1;
        held    = in_data_o;
      end
      @(negedge clk);
      budget++;
    end
    in_ready_i = 1'b0;
    if (expQ.size() != 0) begin
      checkOutput("rx_timeout", expQ.size(), 32'd0);
      expQ.delete();
    end
  endtask

  task automatic checkDone();
    checkOutput("done_pulse", {31'd0, frame_done_o}, 32'd1);
    checkOutput("idle_not_busy", {31'd0, busy_o}, 32'd0);
  endtask

  task automatic stepAndCheckDoneLow();
    @(negedge clk);
    checkOutput("done_single_cycle", {31'd0, frame_done_o}, 32'd0);
  endtask

  initial begin
    reset_i       = 1'b1;
    word_data_i   = 32'h0;
    word_valid_i  = 1'b0;
    frame_start_i = 1'b0;
    frame_len_i   = 8'h00;
    in_ready_i    = 1'b0;
    repeat (3) @(negedge clk);
    reset_i = 1'b0;
    checkOutput("rst_valid", {31'd0, in_valid_o}, 32'd0);
    checkOutput("rst_data", {24'd0, in_data_o}, 32'd0);
    checkOutput("rst_busy", {31'd0, busy_o}, 32'd0);
    checkOutput("rst_done", {31'd0, frame_done_o}, 32'd0);
    checkOutput("rst_ready", {31'd0, word_ready_o}, 32'd1);

    // Single-word frame; the second buffered word must survive for later.
    applyStimulus(32'h11223344);
    applyStimulus(32'hA0B0C0D0);
    startFrame(8'd1);
    expQ = '{8'h5A, 8'h01, 8'h11, 8'h22, 8'h33, 8'h44, 8'h45};
    receiveBytes(1'b0);
    checkDone();

    // Empty frame started in the done cycle (back-to-back).
    startFrame(8'd0);
    expQ = '{8'h5A, 8'h00, 8'h00};
    receiveBytes(1'b0);
    checkDone();
    stepAndCheckDoneLow();
    checkOutput("ready_after_empty", {31'd0, word_ready_o}, 32'd1);

    // Two words under toggling backpressure; first word is the leftover.
    applyStimulus(32'h01020304);
    startFrame(8'd2);
    expQ = '{8'h5A, 8'h02, 8'hA0, 8'hB0, 8'hC0, 8'hD0, 8'h01, 8'h02, 8'h03, 8'h04, 8'h06};
    receiveBytes(1'b1);
    checkDone();
    stepAndCheckDoneLow();

    // Underflow stall at a word boundary, resumed by a late push.
    applyStimulus(32'h55667788);
    startFrame(8'd2);
    expQ = '{8'h5A, 8'h02, 8'h55, 8'h66, 8'h77, 8'h88};
    receiveBytes(1'b0);
    checkOutput("underflow_valid", {31'd0, in_valid_o}, 32'd0);
    @(negedge clk);
    checkOutput("underflow_valid_hold", {31'd0, in_valid_o}, 32'd0);
    checkOutput("underflow_busy", {31'd0, busy_o}, 32'd1);
    applyStimulus(32'h99AABBCC);
    expQ = '{8'h99, 8'hAA, 8'hBB, 8'hCC, 8'h8A};
    receiveBytes(1'b0);
    checkDone();
    stepAndCheckDoneLow();

    // Fill the buffer; the fifth word must be refused.
    checkOutput("ready_w0", {31'd0, word_ready_o}, 32'd1);
    applyStimulus(32'h10000001);
    checkOutput("ready_w1", {31'd0, word_ready_o}, 32'd1);
    applyStimulus(32'h20000002);
    checkOutput("ready_w2", {31'd0, word_ready_o}, 32'd1);
    applyStimulus(32'h30000003);
    checkOutput("ready_w3", {31'd0, word_ready_o}, 32'd1);
    applyStimulus(32'h40000004);
    checkOutput("full_ready_low", {31'd0, word_ready_o}, 32'd0);
    applyStimulus(32'hDEADBEEF);
    checkOutput("full_ready_still_low", {31'd0, word_ready_o}, 32'd0);
    startFrame(8'd4);
    expQ = '{8'h5A, 8'h04, 8'h10, 8'h00, 8'h00, 8'h01, 8'h20, 8'h00, 8'h00, 8'h02,
             8'h30, 8'h00, 8'h00, 8'h03, 8'h40, 8'h00, 8'h00, 8'h04, 8'h40};
    receiveBytes(1'b0);
    checkDone();
    checkOutput("ready_after_drain", {31'd0, word_ready_o}, 32'd1);
    stepAndCheckDoneLow();

    // With the buffer drained, a one-word frame stalls (the refused word is gone).
    startFrame(8'd1);
    expQ = '{8'h5A, 8'h01};
    receiveBytes(1'b0);
    checkOutput("no_fifth_word", {31'd0, in_valid_o}, 32'd0);
    applyStimulus(32'hCAFEF00D);
    applyStimulus(32'hF1F2F3F4);
    expQ = '{8'hCA, 8'hFE};
    receiveBytes(1'b0);

    // Mid-word reset: everything clears and the buffer is flushed.
    reset_i = 1'b1;
    @(negedge clk);
    reset_i = 1'b0;
    checkOutput("midrst_valid", {31'd0, in_valid_o}, 32'd0);
    checkOutput("midrst_data", {24'd0, in_data_o}, 32'd0);
    checkOutput("midrst_busy", {31'd0, busy_o}, 32'd0);
    checkOutput("midrst_ready", {31'd0, word_ready_o}, 32'd1);
    checkOutput("midrst_done", {31'd0, frame_done_o}, 32'd0);
    applyStimulus(32'h12345678);
    startFrame(8'd1);
    expQ = '{8'h5A, 8'h01, 8'h12, 8'h34, 8'h56, 8'h78, 8'h09};
    receiveBytes(1'b0);
    checkDone();
    stepAndCheckDoneLow();

    $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
    $finish;
  end

endmodule

// File: doc/efpga_readback_tx.md
EFPGA_READBACK_TX -- requirements
Module: efpga_readback_tx

Interface
REQ-001 Parameter FIFO_DEPTH, default 4, word-buffer depth in 32-bit words; SHALL be a power of two, at least 2.
REQ-002 Parameter SYNC_BYTE, default 8'h5A, first byte of every frame.
REQ-003 clk_i  input  1  system clock; single clock domain, the same clock as the USB CDC application side.
REQ-004 reset_i  input  1  reset; synchronous, active-high.
REQ-005 word_data_i  input  32  readback word from the eFPGA side.
REQ-006 word_valid_i  input  1  word_data_i valid.
REQ-007 word_ready_o  output  1  word buffer can accept a word.
REQ-008 frame_start_i  input  1  single-cycle request to start a frame.
REQ-009 frame_len_i  input  8  number of words in the frame, 0..255; sampled with frame_start_i.
REQ-010 busy_o  output  1  frame in progress.
REQ-011 frame_done_o  output  1  single-cycle pulse after the checksum byte is accepted.
REQ-012 in_data_o  output  8  byte toward the USB CDC IN channel.
REQ-013 in_valid_o  output  1  in_data_o valid.
REQ-014 in_ready_i  input  1  USB CDC accepts the byte.

Function
REQ-015 Word buffer SHALL be a synchronous FIFO, depth FIFO_DEPTH, with word_ready_o = !full.
REQ-016 A word SHALL be written when word_valid_i && word_ready_o, in any state including IDLE.
REQ-017 If the FIFO is full and a word is popped in the same cycle, word_ready_o SHALL stay low for that cycle (no bypass).
REQ-018 The FSM SHALL have the states IDLE, SYNC, LEN, DATA, CSUM.
REQ-019 IDLE -> SYNC SHALL occur on frame_start_i; frame_len_i SHALL be latched; the checksum SHALL be cleared.
REQ-020 frame_start_i SHALL be ignored in every state other than IDLE.
REQ-021 Latency: frame_start_i at cycle N SHALL give in_valid_o=1 with in_data_o=SYNC_BYTE at cycle N+1.
REQ-022 The byte handshake SHALL complete on in_valid_o && in_ready_i.
REQ-023 While in_valid_o=1 and in_ready_i=0, in_data_o SHALL be held stable.
REQ-024 State sequence after each accepted byte:
  - SYNC -> LEN; LEN emits the latched length byte.
  - LEN -> DATA if length > 0, else -> CSUM.
REQ-025 DATA SHALL pop one FIFO word and emit it as 4 bytes, MSB first (bits 31:24 first).
REQ-026 After the 4th byte is accepted, DATA SHALL pop the next word, or go to CSUM when the word counter reaches the length.
REQ-027 In DATA with the FIFO empty at a word boundary, in_valid_o SHALL be 0 and the FSM SHALL stall; no timeout.
REQ-028 Checksum SHALL be an 8-bit XOR of the length byte and all data bytes; SYNC_BYTE is excluded.
REQ-029 CSUM SHALL emit the checksum byte; on accept -> IDLE with frame_done_o=1 for exactly that cycle.
REQ-030 busy_o SHALL be 1 in every state except IDLE.
REQ-031 Word and byte counters SHALL be 8-bit and 2-bit and SHALL never wrap within a frame; length 255 SHALL emit 1020 data bytes.
REQ-032 Back-to-back frames: frame_start_i in the first IDLE cycle after frame_done_o SHALL be honoured.
REQ-033 FIFO words left over after a frame SHALL be kept for the next frame.

Reset
REQ-034 reset_i=1 at any clock edge, including mid-frame, SHALL force the following on the next cycle:
  - FSM to IDLE.
  - FIFO flushed.
  - in_valid_o=0, in_data_o=8'h00.
  - busy_o=0, frame_done_o=0, word_ready_o=1.
  - Counters and checksum cleared.
REQ-035 No partial frame SHALL resume after reset.

Structure
REQ-036 FSM state encodings and the default SYNC_BYTE SHALL live in the shared controller definitions include, reused by the config receive path.
REQ-037 The FIFO SHALL be the sub-module readback_word_fifo, parameterized by depth and width.
REQ-038 The FSM, serializer and checksum SHALL stay in efpga_readback_tx.

Verification
REQ-039 Single-word frame: push 32'h11223344, frame_start_i with len=1, in_ready_i=1 -> bytes 5A 01 11 22 33 44 45, then frame_done_o pulse.
REQ-040 Empty frame: len=0 -> bytes 5A 00 00; FIFO untouched.
REQ-041 Backpressure: len=2, words 0xA0B0C0D0 and 0x01020304, in_ready_i toggling 1/0 -> in_data_o stable while stalled; sequence 5A 02 A0 B0 C0 D0 01 02 03 04 and checksum 0x02^0xA0^0xB0^0xC0^0xD0^0x01^0x02^0x03^0x04.
REQ-042 Underflow stall: len=2 with one word buffered -> in_valid_o=0 after byte 4 of word 1; push the 2nd word -> stream resumes.
REQ-043 Full FIFO: push 5 words with depth 4 and no frame -> word_ready_o=0 after the 4th word; the 5th word is not accepted.
REQ-044 Mid-frame reset: assert reset_i during DATA -> next cycle in_valid_o=0, busy_o=0, word_ready_o=1; a new frame starts with 5A.
